ftdi_cmd_parser: RTL and testbench
==================================

// Module: ftdi_cmd_parser
// PURPOSE
//  Byte-level command parser downstream of the FTDI RD async FIFO and upstream of the FTDI WR async FIFO.
//  Pops host bytes, frames fixed 5-byte commands and executes 8-bit register writes/reads.
//  Pushes a fixed 4-byte response frame per command (ack, read data or error).
//  Runs entirely in the clk_i domain (FIFO read/write side).
// PARAMETERS
//  SYNC_BYTE    8'hA5  first byte of every host command frame
//  RESP_BYTE    8'h5A  first byte of every response frame
//  TIMEOUT_CYC  65535  idle cycles allowed mid-frame before abort (16-bit counter, must be >= 2)
// PORTS
//  clk_i          in   1  clock
//  async_rst_n    in   1  reset, asynchronous, active-low
//  rd_fifo_empty  in   1  RD FIFO empty
//  rd_fifo_data   in   8  RD FIFO read data, valid 1 cycle after rd_fifo_rd_en
//  rd_fifo_rd_en  out  1  RD FIFO pop strobe
//  wr_fifo_full   in   1  WR FIFO full
//  wr_fifo_wr_en  out  1  WR FIFO push strobe
//  wr_fifo_data   out  8  WR FIFO push data, valid with wr_fifo_wr_en
//  reg_wr_en      out  1  register write strobe, 1 cycle
//  reg_rd_en      out  1  register read strobe, 1 cycle
//  reg_addr       out  8  register address, valid with either strobe
//  reg_wdata      out  8  register write data, valid with reg_wr_en
//  reg_rdata      in   8  register read data, sampled 1 cycle after reg_rd_en
//  err_chk        out  1  pulse: checksum mismatch
//  err_cmd        out  1  pulse: unknown opcode
//  err_timeout    out  1  pulse: mid-frame timeout
//  busy           out  1  high in any state other than HUNT
// BEHAVIOUR
//  Frame in: SYNC, CMD, ADDR, DATA, CHK; CHK = CMD^ADDR^DATA. CMD 8'h01 = write, 8'h02 = read.
//  Frame out: RESP_BYTE, R1, R2, R1^R2.
//    write ok: R1=8'h01, R2=DATA.
//    read ok:  R1=8'h02, R2=reg_rdata.
//    checksum error: R1=8'hEE, R2=8'h01.
//    opcode error:   R1=8'hEE, R2=8'h02.
//  Reset: all outputs 0; state HUNT; byte-pending flag, timeout counter and response index cleared.
//  Byte fetch
//    - rd_fifo_rd_en = state in {HUNT,GET_CMD,GET_ADDR,GET_DATA,GET_CHK} & !rd_fifo_empty & !pending.
//    - pending sets on pop; byte consumed and pending cleared the next cycle.
//    - At most one pop outstanding; a byte arriving after a state change is never lost.
//  States
//    HUNT     : discard bytes != SYNC_BYTE; SYNC_BYTE -> GET_CMD.
//    GET_CMD, GET_ADDR, GET_DATA : latch byte, advance to next state.
//    GET_CHK  : latch byte -> EXEC.
//    EXEC (1 cycle), checked in this order:
//      1. CHK mismatch -> err_chk, error response, no reg strobe.
//      2. else CMD==01 -> reg_wr_en -> RESP.
//      3. else CMD==02 -> reg_rd_en -> RD_WAIT.
//      4. else err_cmd, error response.
//    RD_WAIT  : capture reg_rdata -> RESP.
//    RESP     : 2-bit index 0..3; push byte[index] when !wr_fifo_full.
//               Index advances only on push; after index 3 -> HUNT. No RD FIFO pops in RESP.
//  Output registering: reg strobes, addr, wdata, err pulses, wr_fifo_wr_en and wr_fifo_data are registered.
//    reg_wr_en/reg_rd_en rise the cycle after EXEC is entered.
//  Timeout
//    - Counter runs in GET_* states while no byte is consumed; clears on each consumed byte and in other states.
//    - At TIMEOUT_CYC-1: err_timeout pulse, go to HUNT, no response.
//    - If a pop is pending at timeout, its byte is consumed as a HUNT byte.
//  Simultaneous events
//    - wr_fifo_full holds output stable; no pushes while full.
//    - rd_fifo_empty during GET_* only stalls.
//  Reset mid-operation: frame and unsent response are discarded; no partial strobes after reset release.
// TESTING
//  1. Push A5 01 10 3C 2D -> one reg_wr_en pulse with addr 10, wdata 3C; WR FIFO receives 5A 01 3C 3D.
//  2. Push A5 02 20 00 22, reg_rdata=77 -> one reg_rd_en pulse with addr 20; WR FIFO receives 5A 02 77 75.
//  3. Push A5 01 10 3C 00 -> err_chk pulse, no reg strobe; WR FIFO receives 5A EE 01 EF.
//  4. Push 00 FF A5 03 11 22 30 -> leading bytes dropped, err_cmd pulse; WR FIFO receives 5A EE 02 EC.
//  5. TIMEOUT_CYC=16: push A5 01, then stall -> err_timeout 16 idle cycles later, no response;
//     then test 1 frame -> normal result.
//  6. Hold wr_fifo_full high during test 2 response for 10 cycles -> no push while full;
//     5A 02 77 75 delivered in order after release.

Source files
------------

// File: rtl/ftdi_cmd_parser.sv
// Byte-level command parser between the FTDI RD and WR async FIFOs: frames 5-byte host
// commands, performs 8-bit register writes/reads and pushes a 4-byte response per command.
module ftdi_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  RESP_BYTE   = 8'h5A,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk_i,
  input  logic       async_rst_n,
  input  logic       rd_fifo_empty,
  input  logic [7:0] rd_fifo_data,
  output logic       rd_fifo_rd_en,
  input  logic       wr_fifo_full,
  output logic       wr_fifo_wr_en,
  output logic [7:0] wr_fifo_data,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       err_chk,
  output logic       err_cmd,
  output logic       err_timeout,
  output logic       busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  OP_WR    = 8'h01;
  localparam logic [7:0]  OP_RD    = 8'h02;
  localparam logic [7:0]  R1_ERR   = 8'hEE;
  localparam logic [7:0]  R2_CHK   = 8'h01;
  localparam logic [7:0]  R2_CMD   = 8'h02;

  typedef enum logic [2:0] {
    S_HUNT, S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK, S_EXEC, S_RD_WAIT, S_RESP
  } state_t;

  state_t      r_state;
  logic        r_pending;
  logic [15:0] r_tmo;
  logic [1:0]  r_idx;
  logic [7:0]  r_cmd, r_addr, r_data, r_chk, r_r1, r_r2;
  logic        r_reg_wr_en, r_reg_rd_en, r_err_chk, r_err_cmd, r_err_timeout, r_wr_en;
  logic [7:0]  r_reg_addr, r_reg_wdata, r_wr_data;

  logic        w_fetch, w_get, w_pop, w_timeout, w_chk_ok;
  logic [7:0]  w_resp_byte;

  assign w_fetch   = r_state inside {S_HUNT, S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK};
  assign w_get     = r_state inside {S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK};
  // A pop is only issued when no earlier pop is still waiting to be consumed.
  assign w_pop     = w_fetch & ~rd_fifo_empty & ~r_pending;
  assign w_timeout = w_get & ~r_pending & (r_tmo == TMO_LAST);
  assign w_chk_ok  = (r_chk == (r_cmd ^ r_addr ^ r_data));

  always_comb begin
    w_resp_byte = RESP_BYTE;
    case (r_idx)
      2'd0:    w_resp_byte = RESP_BYTE;
      2'd1:    w_resp_byte = r_r1;
      2'd2:    w_resp_byte = r_r2;
      default: w_resp_byte = r_r1 ^ r_r2;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state       <= S_HUNT;
      r_pending     <= 1'b0;
      r_tmo         <= '0;
      r_idx         <= '0;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_chk         <= '0;
      r_r1          <= '0;
      r_r2          <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_rd_en   <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wr_en       <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_wdata   <= '0;
      r_wr_data     <= '0;
    end else begin
      r_reg_wr_en   <= 1'b0;
      r_reg_rd_en   <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wr_en       <= 1'b0;
      r_pending     <= w_pop;
      r_tmo         <= (w_get && !r_pending && !w_timeout) ? r_tmo + 16'd1 : '0;

      case (r_state)
        S_HUNT:
          if (r_pending && rd_fifo_data == SYNC_BYTE) r_state <= S_GET_CMD;
        S_GET_CMD:
          if (r_pending) begin
            r_cmd   <= rd_fifo_data;
            r_state <= S_GET_ADDR;
          end
        S_GET_ADDR:
          if (r_pending) begin
            r_addr  <= rd_fifo_data;
            r_state <= S_GET_DATA;
          end
        S_GET_DATA:
          if (r_pending) begin
            r_data  <= rd_fifo_data;
            r_state <= S_GET_CHK;
          end
        S_GET_CHK:
          if (r_pending) begin
            r_chk   <= rd_fifo_data;
            r_state <= S_EXEC;
          end
        // Checksum is judged before the opcode, so a corrupted frame never strobes the bus.
        S_EXEC: begin
          r_idx <= '0;
          if (!w_chk_ok) begin
            r_err_chk <= 1'b1;
            r_r1      <= R1_ERR;
            r_r2      <= R2_CHK;
            r_state   <= S_RESP;
          end else if (r_cmd == OP_WR) begin
            r_reg_wr_en <= 1'b1;
            r_reg_addr  <= r_addr;
            r_reg_wdata <= r_data;
            r_r1        <= OP_WR;
            r_r2        <= r_data;
            r_state     <= S_RESP;
          end else if (r_cmd == OP_RD) begin
            r_reg_rd_en <= 1'b1;
            r_reg_addr  <= r_addr;
            r_r1        <= OP_RD;
            r_state     <= S_RD_WAIT;
          end else begin
            r_err_cmd <= 1'b1;
            r_r1      <= R1_ERR;
            r_r2      <= R2_CMD;
            r_state   <= S_RESP;
          end
        end
        S_RD_WAIT: begin
          r_r2    <= reg_rdata;
          r_state <= S_RESP;
        end
        S_RESP:
          if (!wr_fifo_full) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_resp_byte;
            r_idx     <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_HUNT;
          end
        default: r_state <= S_HUNT;
      endcase

      // Only reachable with no byte pending this cycle; a pop issued now lands in HUNT.
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
        r_state       <= S_HUNT;
      end
    end
  end

  assign rd_fifo_rd_en = w_pop;
  assign wr_fifo_wr_en = r_wr_en;
  assign wr_fifo_data  = r_wr_data;
  assign reg_wr_en     = r_reg_wr_en;
  assign reg_rd_en     = r_reg_rd_en;
  assign reg_addr      = r_reg_addr;
  assign reg_wdata     = r_reg_wdata;
  assign err_chk       = r_err_chk;
  assign err_cmd       = r_err_cmd;
  assign err_timeout   = r_err_timeout;
  assign busy          = (r_state != S_HUNT);

endmodule

// File: tb/tb_ftdi_cmd_parser.sv
// Self-checking bench for ftdi_cmd_parser: directed frames from the block's test list plus
// randomized frames with FIFO stalls, scored against a frame-level reference model.
module tb_ftdi_cmd_parser;
  localparam int TMO = 16;

  logic       clk_i = 1'b0;
  logic       async_rst_n;
  logic       rd_fifo_empty;
  logic [7:0] rd_fifo_data;
  logic       rd_fifo_rd_en;
  logic       wr_fifo_full;
  logic       wr_fifo_wr_en;
  logic [7:0] wr_fifo_data;
  logic       reg_wr_en, reg_rd_en;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       err_chk, err_cmd, err_timeout, busy;

  always #5 clk_i = ~clk_i;

  ftdi_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .async_rst_n(async_rst_n),
    .rd_fifo_empty(rd_fifo_empty), .rd_fifo_data(rd_fifo_data), .rd_fifo_rd_en(rd_fifo_rd_en),
    .wr_fifo_full(wr_fifo_full), .wr_fifo_wr_en(wr_fifo_wr_en), .wr_fifo_data(wr_fifo_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .err_chk(err_chk), .err_cmd(err_cmd), .err_timeout(err_timeout),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rdMem [0:4095];
  int         rdHead = 0, rdTail = 0, stallRun = 0;
  logic       rdStall = 1'b0, fullAtEdge = 1'b0;
  bit         rdStallEn = 1'b0, fullRandEn = 1'b0, fullForce = 1'b0;
  logic [7:0] leadq[$];
  logic [7:0] got[$];
  int         wrCount, rdCount, errChkCount, errCmdCount, errTmoCount, fullPushes;
  logic [7:0] lastWrAddr, lastWrData, lastRdAddr;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs only change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    fullAtEdge = wr_fifo_full;
    if (rdStallEn && stallRun < 3 && $urandom_range(0, 2) == 0) begin
      rdStall = 1'b1;
      stallRun++;
    end else begin
      rdStall  = 1'b0;
      stallRun = 0;
    end
    wr_fifo_full  = fullForce || (fullRandEn && $urandom_range(0, 3) == 0);
    rd_fifo_empty = rdStall || (rdHead == rdTail);
    @(negedge clk_i);
    if (wr_fifo_wr_en) begin
      if (fullAtEdge) fullPushes++;
      got.push_back(wr_fifo_data);
    end
    if (reg_wr_en) begin
      wrCount++;
      lastWrAddr = reg_addr;
      lastWrData = reg_wdata;
    end
    if (reg_rd_en) begin
      rdCount++;
      lastRdAddr = reg_addr;
    end
    if (err_chk) errChkCount++;
    if (err_cmd) errCmdCount++;
    if (err_timeout) errTmoCount++;
    if (rd_fifo_rd_en) begin
      rd_fifo_data = rdMem[rdHead % 4096];
      rdHead++;
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    rdMem[rdTail % 4096] = b;
    rdTail++;
  endtask

  task automatic clearMonitors();
    got.delete();
    wrCount = 0; rdCount = 0; errChkCount = 0; errCmdCount = 0; errTmoCount = 0; fullPushes = 0;
  endtask

  function automatic void refModel(input logic [7:0] cmd, addr, data, chk, rdata,
                                   output logic [7:0] r1, r2,
                                   output int nWr, nRd, nChk, nCmd);
    nWr = 0; nRd = 0; nChk = 0; nCmd = 0;
    if ((cmd ^ addr ^ data) != chk) begin r1 = 8'hEE; r2 = 8'h01; nChk = 1; end
    else if (cmd == 8'h01)          begin r1 = 8'h01; r2 = data;  nWr = 1; end
    else if (cmd == 8'h02)          begin r1 = 8'h02; r2 = rdata; nRd = 1; end
    else                            begin r1 = 8'hEE; r2 = 8'h02; nCmd = 1; end
  endfunction

  task automatic applyStimulus(input logic [7:0] cmd, addr, data, chk, rdata);
    clearMonitors();
    reg_rdata = rdata;
    foreach (leadq[i]) pushByte(leadq[i]);
    leadq.delete();
    pushByte(8'hA5); pushByte(cmd); pushByte(addr); pushByte(data); pushByte(chk);
  endtask

  task automatic waitResponse();
    int n = 0;
    while (!(got.size() >= 4 && !busy) && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] cmd, addr, data, chk, rdata);
    logic [7:0] r1, r2, obs;
    logic [7:0] expB [4];
    int nWr, nRd, nChk, nCmd;
    refModel(cmd, addr, data, chk, rdata, r1, r2, nWr, nRd, nChk, nCmd);
    expB[0] = 8'h5A; expB[1] = r1; expB[2] = r2; expB[3] = r1 ^ r2;
    checkInt({tag, "_resp_len"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      obs = (i < got.size()) ? got[i] : 8'hxx;
      check8($sformatf("%s_byte%0d", tag, i), obs, expB[i]);
    end
    checkInt({tag, "_wr_strobes"}, wrCount, nWr);
    checkInt({tag, "_rd_strobes"}, rdCount, nRd);
    checkInt({tag, "_err_chk"}, errChkCount, nChk);
    checkInt({tag, "_err_cmd"}, errCmdCount, nCmd);
    checkInt({tag, "_err_timeout"}, errTmoCount, 0);
    checkInt({tag, "_push_while_full"}, fullPushes, 0);
    if (nWr == 1) begin
      check8({tag, "_wr_addr"}, lastWrAddr, addr);
      check8({tag, "_wr_data"}, lastWrData, data);
    end
    if (nRd == 1) check8({tag, "_rd_addr"}, lastRdAddr, addr);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] cmd, addr, data, chk, rdata);
    applyStimulus(cmd, addr, data, chk, rdata);
    waitResponse();
    checkOutput(tag, cmd, addr, data, chk, rdata);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check8({tag, "_wr_en"},   {7'd0, wr_fifo_wr_en}, 8'h00);
    check8({tag, "_wr_data"}, wr_fifo_data, 8'h00);
    check8({tag, "_rd_en"},   {7'd0, rd_fifo_rd_en}, 8'h00);
    check8({tag, "_reg_wr"},  {7'd0, reg_wr_en}, 8'h00);
    check8({tag, "_reg_rd"},  {7'd0, reg_rd_en}, 8'h00);
    check8({tag, "_addr"},    reg_addr, 8'h00);
    check8({tag, "_wdata"},   reg_wdata, 8'h00);
    check8({tag, "_errs"},    {5'd0, err_chk, err_cmd, err_timeout}, 8'h00);
    check8({tag, "_busy"},    {7'd0, busy}, 8'h00);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] cmd, addr, data, chk, b;
    int n;
    async_rst_n   = 1'b0;
    rd_fifo_empty = 1'b1;
    rd_fifo_data  = 8'h00;
    wr_fifo_full  = 1'b0;
    reg_rdata     = 8'h00;
    clearMonitors();
    repeat (3) tick();
    checkIdleOutputs("reset");
    async_rst_n = 1'b1;
    repeat (2) tick();

    runFrame("t1_write", 8'h01, 8'h10, 8'h3C, 8'h2D, 8'h00);
    runFrame("t2_read", 8'h02, 8'h20, 8'h00, 8'h22, 8'h77);
    runFrame("t3_badchk", 8'h01, 8'h10, 8'h3C, 8'h00, 8'h00);
    leadq.push_back(8'h00);
    leadq.push_back(8'hFF);
    runFrame("t4_badop", 8'h03, 8'h11, 8'h22, 8'h30, 8'h00);

    // Partial frame followed by silence must time out without any response.
    clearMonitors();
    pushByte(8'hA5);
    pushByte(8'h01);
    n = 0;
    while (errTmoCount == 0 && n < 60) begin
      tick();
      n++;
      if (n == 6) check8("t5_busy_midframe", {7'd0, busy}, 8'h01);
    end
    checkInt("t5_tmo_window", int'(n >= 17 && n <= 24), 1);
    repeat (4) tick();
    checkInt("t5_tmo_pulses", errTmoCount, 1);
    checkInt("t5_no_resp", got.size(), 0);
    checkInt("t5_no_strobes", wrCount + rdCount, 0);
    check8("t5_busy_after", {7'd0, busy}, 8'h00);
    runFrame("t5_recover", 8'h01, 8'h10, 8'h3C, 8'h2D, 8'h00);

    fullForce = 1'b1;
    applyStimulus(8'h02, 8'h20, 8'h00, 8'h22, 8'h77);
    repeat (25) tick();
    checkInt("t6_held_no_push", got.size(), 0);
    check8("t6_busy_held", {7'd0, busy}, 8'h01);
    fullForce = 1'b0;
    waitResponse();
    checkOutput("t6_full_release", 8'h02, 8'h20, 8'h00, 8'h22, 8'h77);

    // Reset in the middle of a read frame discards it completely.
    clearMonitors();
    pushByte(8'hA5); pushByte(8'h02); pushByte(8'h20);
    repeat (8) tick();
    async_rst_n = 1'b0;
    repeat (2) tick();
    checkIdleOutputs("midrst");
    async_rst_n = 1'b1;
    repeat (6) tick();
    checkInt("midrst_no_activity", got.size() + wrCount + rdCount, 0);
    runFrame("midrst_recover", 8'h02, 8'h44, 8'h00, 8'h46, 8'hC3);

    rdStallEn  = 1'b1;
    fullRandEn = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        do b = 8'($urandom); while (b == 8'hA5);
        leadq.push_back(b);
      end
      n    = int'($urandom_range(0, 9));
      cmd  = (n < 4) ? 8'h01 : (n < 8) ? 8'h02 : 8'($urandom);
      addr = 8'($urandom);
      data = 8'($urandom);
      chk  = cmd ^ addr ^ data;
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      runFrame($sformatf("rnd%0d", f), cmd, addr, data, chk, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
